// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: records (PC, write-back data) whenever WriteData changes,
// drains via valid/ready, and folds every event into a rotating signature.
module wb_trace_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [31:0]            PCValue,
   input  logic [31:0]            WriteData,
   input  logic                   Freeze,
   input  logic                   RdReady,
   output logic                   RdValid,
   output logic [31:0]            RdPC,
   output logic [31:0]            RdData,
   output logic [$clog2(DEPTH):0] Count,
   output logic                   Overflow,
   output logic [31:0]            Signature
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   wr_entry_d;
   logic [31:0]   prev_wd_q, prev_wd_d;
   logic          prev_valid_q, prev_valid_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   sig_q, sig_d;
   logic          ev;
   logic          pop;
   logic          push;

   // event detection, handshake decode and next-state for all registers
   always_comb begin
      ev           = !Freeze && (!prev_valid_q || (WriteData != prev_wd_q));
      pop          = (count_q != '0) && RdReady;
      push         = ev && ((count_q != FULL) || pop);
      wr_entry_d   = {PCValue, WriteData};
      prev_wd_d    = WriteData;
      prev_valid_d = 1'b1;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      sig_d        = sig_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
      if (ev && !push) begin
         overflow_d = 1'b1;
      end
      if (ev) begin
         sig_d = {sig_q[30:0], sig_q[31]} ^ WriteData;
      end
   end

   // control and tracking registers, synchronous reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         prev_wd_q    <= '0;
         prev_valid_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         sig_q        <= '0;
      end else begin
         prev_wd_q    <= prev_wd_d;
         prev_valid_q <= prev_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         sig_q        <= sig_d;
      end
   end

   // entry storage; contents stay hidden behind the empty gate after reset
   always_ff @(posedge Clk) begin
      if (push && !Rst) begin
         mem_q[wr_ptr_q] <= wr_entry_d;
      end
   end

   // head outputs, forced to zero while empty
   always_comb begin
      RdValid   = (count_q != '0);
      RdPC      = '0;
      RdData    = '0;
      if (RdValid) begin
         {RdPC, RdData} = mem_q[rd_ptr_q];
      end
      Count     = count_q;
      Overflow  = overflow_q;
      Signature = sig_q;
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: directed table vectors plus hand-written sequences
// for full/overflow, simultaneous push/pop, freeze/wrap and mid-run reset.
module tb_wb_trace_fifo;
   localparam int DEPTH = 16;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [31:0] PCValue = '0;
   logic [31:0] WriteData = '0;
   logic        Freeze = 1'b0;
   logic        RdReady = 1'b0;
   logic        RdValid;
   logic [31:0] RdPC;
   logic [31:0] RdData;
   logic [4:0]  Count;
   logic        Overflow;
   logic [31:0] Signature;

   int checks = 0;
   int failures = 0;

   logic [63:0] mq[$];
   logic [31:0] m_prev = '0;
   logic        m_pv = 1'b0;
   logic        m_ovf = 1'b0;
   logic [31:0] m_sig = '0;

   typedef struct {
      logic        rst;
      logic [31:0] wd;
      logic        frz;
      logic        rdy;
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_d;
      logic [31:0] e_c;
      logic        e_o;
      logic [31:0] e_s;
   } vec_t;

   vec_t tbl[15];

   wb_trace_fifo #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .PCValue(PCValue), .WriteData(WriteData),
      .Freeze(Freeze), .RdReady(RdReady), .RdValid(RdValid),
      .RdPC(RdPC), .RdData(RdData), .Count(Count),
      .Overflow(Overflow), .Signature(Signature)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick(input logic r, input logic [31:0] pc,
                       input logic [31:0] wd, input logic f,
                       input logic rd);
      logic ev, pop, push;
      Rst = r;
      PCValue = pc;
      WriteData = wd;
      Freeze = f;
      RdReady = rd;
      @(posedge Clk);
      if (r) begin
         mq.delete();
         m_prev = '0;
         m_pv = 1'b0;
         m_ovf = 1'b0;
         m_sig = '0;
      end else begin
         ev = !f && (!m_pv || wd != m_prev);
         pop = (mq.size() != 0) && rd;
         push = ev && (mq.size() < DEPTH || pop);
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back({pc, wd});
         if (ev && !push) m_ovf = 1'b1;
         if (ev) m_sig = {m_sig[30:0], m_sig[31]} ^ wd;
         m_prev = wd;
         m_pv = 1'b1;
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [63:0] h;
      h = (mq.size() != 0) ? mq[0] : 64'h0;
      chk({tag, ".count"}, 32'(Count), 32'(mq.size()));
      chk({tag, ".valid"}, 32'(RdValid), 32'(mq.size() != 0));
      chk({tag, ".pc"}, RdPC, h[63:32]);
      chk({tag, ".data"}, RdData, h[31:0]);
      chk({tag, ".ovf"}, 32'(Overflow), 32'(m_ovf));
      chk({tag, ".sig"}, Signature, m_sig);
   endtask

   task automatic fill(input int n, input logic [31:0] base,
                       input logic [31:0] pcb);
      for (int i = 0; i < n; i++) begin
         tick(1'b0, pcb + 32'(4 * i), base + 32'(i), 1'b0, 1'b0);
         check_model("fill");
      end
   endtask

   initial begin
      logic [31:0] exp_d;
      logic        exp_v;
      logic [31:0] a_val;
      logic [31:0] b_val;

      // rst wd frz rdy | valid pc data count ovf sig
      tbl[0]  = '{1, 32'h5, 0, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0};
      tbl[1]  = '{1, 32'h5, 0, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0};
      tbl[2]  = '{0, 32'h5, 0, 0, 1, 32'h108, 32'h5, 1, 0, 32'h5};
      tbl[3]  = '{0, 32'h5, 0, 0, 1, 32'h108, 32'h5, 1, 0, 32'h5};
      tbl[4]  = '{0, 32'h5, 0, 0, 1, 32'h108, 32'h5, 1, 0, 32'h5};
      tbl[5]  = '{0, 32'hA, 0, 0, 1, 32'h108, 32'h5, 2, 0, 32'h0};
      tbl[6]  = '{0, 32'hA, 0, 0, 1, 32'h108, 32'h5, 2, 0, 32'h0};
      tbl[7]  = '{0, 32'h3, 0, 0, 1, 32'h108, 32'h5, 3, 0, 32'h3};
      tbl[8]  = '{0, 32'h3, 0, 1, 1, 32'h114, 32'hA, 2, 0, 32'h3};
      tbl[9]  = '{0, 32'h7, 1, 1, 1, 32'h11C, 32'h3, 1, 0, 32'h3};
      tbl[10] = '{0, 32'h7, 0, 0, 1, 32'h11C, 32'h3, 1, 0, 32'h3};
      tbl[11] = '{0, 32'h7, 0, 1, 0, 32'h0,   32'h0, 0, 0, 32'h3};
      tbl[12] = '{0, 32'h7, 0, 1, 0, 32'h0,   32'h0, 0, 0, 32'h3};
      tbl[13] = '{0, 32'h9, 0, 1, 1, 32'h134, 32'h9, 1, 0, 32'hF};
      tbl[14] = '{0, 32'h9, 0, 1, 0, 32'h0,   32'h0, 0, 0, 32'hF};

      for (int k = 0; k < 15; k++) begin
         tick(tbl[k].rst, 32'h100 + 32'(4 * k), tbl[k].wd,
              tbl[k].frz, tbl[k].rdy);
         chk($sformatf("v%0d.valid", k), 32'(RdValid), 32'(tbl[k].e_v));
         chk($sformatf("v%0d.pc", k), RdPC, tbl[k].e_pc);
         chk($sformatf("v%0d.data", k), RdData, tbl[k].e_d);
         chk($sformatf("v%0d.count", k), 32'(Count), tbl[k].e_c);
         chk($sformatf("v%0d.ovf", k), 32'(Overflow), 32'(tbl[k].e_o));
         chk($sformatf("v%0d.sig", k), Signature, tbl[k].e_s);
      end

      // 18 distinct values into an empty FIFO: two drops
      tick(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      fill(18, 32'h100, 32'h2000);
      chk("full.count", 32'(Count), 32'd16);
      chk("full.ovf", 32'(Overflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("drain18.valid", 32'(RdValid), 32'd1);
         chk("drain18.data", RdData, 32'h100 + 32'(i));
         chk("drain18.pc", RdPC, 32'h2000 + 32'(4 * i));
         tick(1'b0, 32'h0, 32'h111, 1'b0, 1'b1);
      end
      chk("drain18.empty", 32'(RdValid), 32'd0);
      chk("drain18.count", 32'(Count), 32'd0);

      // push and pop together while full
      tick(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      fill(16, 32'h300, 32'h3000);
      chk("pp.full", 32'(Count), 32'd16);
      tick(1'b0, 32'h4000, 32'h400, 1'b0, 1'b1);
      check_model("pp");
      chk("pp.count", 32'(Count), 32'd16);
      chk("pp.ovf", 32'(Overflow), 32'd0);
      chk("pp.head", RdData, 32'h301);
      for (int i = 0; i < 16; i++) begin
         exp_d = (i < 15) ? 32'h301 + 32'(i) : 32'h400;
         chk("pp.drain", RdData, exp_d);
         tick(1'b0, 32'h0, 32'h400, 1'b0, 1'b1);
      end
      chk("pp.empty", 32'(RdValid), 32'd0);
      chk("pp.ovf_end", 32'(Overflow), 32'd0);

      // freeze window with continuous draining; pointers wrap twice
      a_val = 32'hAAAA_0001;
      b_val = 32'h5555_0002;
      for (int i = 0; i < 40; i++) begin
         exp_v = (i > 0) && !((i - 1) >= 10 && (i - 1) <= 14);
         chk("fz.valid", 32'(RdValid), 32'(exp_v));
         if (exp_v) begin
            chk("fz.pc", RdPC, 32'h5000 + 32'(4 * (i - 1)));
            chk("fz.data", RdData, ((i - 1) % 2 == 1) ? b_val : a_val);
         end
         chk("fz.count_le1", 32'(Count <= 5'd1), 32'd1);
         tick(1'b0, 32'h5000 + 32'(4 * i), (i % 2 == 1) ? b_val : a_val,
              (i >= 10 && i <= 14), 1'b1);
         check_model("fz");
      end

      // reset mid-run with 7 entries held and Overflow set
      tick(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      fill(18, 32'h600, 32'h6000);
      for (int i = 0; i < 9; i++) begin
         tick(1'b0, 32'h0, 32'h611, 1'b0, 1'b1);
      end
      chk("mr.count7", 32'(Count), 32'd7);
      chk("mr.ovf1", 32'(Overflow), 32'd1);
      tick(1'b1, 32'h6FFC, 32'h777, 1'b0, 1'b0);
      chk("mr.valid", 32'(RdValid), 32'd0);
      chk("mr.pc", RdPC, 32'h0);
      chk("mr.data", RdData, 32'h0);
      chk("mr.count", 32'(Count), 32'd0);
      chk("mr.ovf", 32'(Overflow), 32'd0);
      chk("mr.sig", Signature, 32'h0);
      tick(1'b0, 32'h7000, 32'h777, 1'b0, 1'b0);
      chk("mr.cap_valid", 32'(RdValid), 32'd1);
      chk("mr.cap_pc", RdPC, 32'h7000);
      chk("mr.cap_data", RdData, 32'h777);
      chk("mr.cap_count", 32'(Count), 32'd1);
      chk("mr.cap_sig", Signature, 32'h777);
      check_model("mr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
